mem_arbiter: RTL and testbench

Two-port memory arbiter between the processor's instruction and data request ports and the single-ported RAM model. It sits directly downstream of the processor and upstream of the RAM/testbench control mux. It serialises requests, holds one grant until the RAM reports completion, and returns data and wait signals to the winning port. Fixed data-over-instruction priority is the default; round-robin is a build option.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Processor/RAM signal bundle for mem_arbiter.
// master = arbiter view, slave = processor/RAM environment view.
interface mem_arbiter_if;
  localparam int unsigned DataW  = 32;
  localparam int unsigned StateW = 2;

  logic              iREN;
  logic [DataW-1:0]  iaddr;
  logic              iwait;
  logic [DataW-1:0]  iload;

  logic              dREN;
  logic              dWEN;
  logic [DataW-1:0]  daddr;
  logic [DataW-1:0]  dstore;
  logic              dwait;
  logic [DataW-1:0]  dload;

  logic              ramREN;
  logic              ramWEN;
  logic [DataW-1:0]  ramaddr;
  logic [DataW-1:0]  ramstore;
  logic [DataW-1:0]  ramload;
  logic [StateW-1:0] ramstate;

  logic              memerr;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter in front of a single-ported RAM; holds one grant until completion.
// Build option MEM_ARB_RR_EN: round-robin instead of fixed data-over-instruction priority.
module mem_arbiter (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus
);
  localparam int unsigned DataW = 32;
  localparam logic [1:0]  RamAccess = 2'd2;
  localparam logic [1:0]  RamError  = 2'd3;

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_e;

  state_e state_q, state_d;
  logic   memerr_q, memerr_d;
  logic   d_req;
  logic   done;
  logic   err;

`ifdef MEM_ARB_RR_EN
  // 1 when the data port held the most recent completed grant
  logic   last_d_q, last_d_d;
`endif

  assign d_req = bus.dREN | bus.dWEN;
  assign done  = (bus.ramstate == RamAccess) || (bus.ramstate == RamError);
  assign err   = (bus.ramstate == RamError);

  assign bus.memerr = memerr_q;
  assign bus.iload  = bus.ramload;
  assign bus.dload  = bus.ramload;

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q  <= IDLE;
      memerr_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      memerr_q <= memerr_d;
`ifdef MEM_ARB_RR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    memerr_d     = memerr_q;
`ifdef MEM_ARB_RR_EN
    last_d_d     = last_d_q;
`endif
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = DataW'(0);
    bus.ramstore = DataW'(0);
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;

    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (d_req && bus.iREN) state_d = last_d_q ? GNT_I : GNT_D;
        else if (d_req)        state_d = GNT_D;
        else if (bus.iREN)     state_d = GNT_I;
`else
        if (d_req)             state_d = GNT_D;
        else if (bus.iREN)     state_d = GNT_I;
`endif
      end

      GNT_D: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = ~bus.dWEN;
          if (done) begin
            bus.dwait = 1'b0;
            state_d   = IDLE;
            if (err) memerr_d = 1'b1;
`ifdef MEM_ARB_RR_EN
            last_d_d  = 1'b1;
`endif
          end
        end
      end

      GNT_I: begin
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (done) begin
            bus.iwait = 1'b0;
            state_d   = IDLE;
            if (err) memerr_d = 1'b1;
`ifdef MEM_ARB_RR_EN
            last_d_d  = 1'b0;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small latency-L RAM model.
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic CLK;
  logic nRST;
  int   checks   = 0;
  int   failures = 0;
  int   cnt      = 0;
  int   lat      = 2;
  logic err_inj  = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: BUSY until the strobe has been up for lat cycles, then ACCESS (or ERROR)
  assign bus.ramstate = (bus.ramREN | bus.ramWEN)
                        ? ((cnt == lat) ? (err_inj ? 2'd3 : 2'd2) : 2'd1)
                        : 2'd0;

  always @(posedge CLK) begin
    if (!(bus.ramREN | bus.ramWEN) || bus.ramstate[1]) cnt <= 0;
    else                                                cnt <= cnt + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.iREN = 1'b1;  bus.iaddr  = 32'h40;
    bus.dREN = 1'b0;  bus.dWEN   = 1'b0;
    bus.daddr = 32'h0; bus.dstore = 32'h0;
    bus.ramload = 32'hDEADBEEF;
    nRST = 1'b1;

    // reset held with a pending fetch
    tick(); tick();
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_iwait",  32'(bus.iwait),  32'd1);
    chk("rst_dwait",  32'(bus.dwait),  32'd1);
    chk("rst_memerr", 32'(bus.memerr), 32'd0);
    chk("rst_ramaddr", bus.ramaddr,    32'h0);

    // single fetch, L = 2
    nRST = 1'b0; #1;
    chk("idle_ramREN", 32'(bus.ramREN), 32'd0);
    tick();
    chk("fetch_ramREN",   32'(bus.ramREN), 32'd1);
    chk("fetch_ramaddr",  bus.ramaddr,     32'h40);
    chk("fetch_ramstore", bus.ramstore,    32'h0);
    chk("fetch_iwait1",   32'(bus.iwait),  32'd1);
    tick();
    chk("fetch_iwait2",   32'(bus.iwait),  32'd1);
    tick();
    chk("fetch_iwait_done", 32'(bus.iwait), 32'd0);
    chk("fetch_iload",    bus.iload,       32'hDEADBEEF);
    chk("fetch_dwait",    32'(bus.dwait),  32'd1);
    tick();
    bus.iREN = 1'b0; #1;
    chk("post_ramREN", 32'(bus.ramREN), 32'd0);
    chk("post_iwait",  32'(bus.iwait),  32'd1);

    // contention: data write first, then fetch
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h5;
    bus.ramload = 32'h12345678;
    tick();
    chk("cw_ramWEN",   32'(bus.ramWEN), 32'd1);
    chk("cw_ramREN",   32'(bus.ramREN), 32'd0);
    chk("cw_ramaddr",  bus.ramaddr,     32'h100);
    chk("cw_ramstore", bus.ramstore,    32'h5);
    chk("cw_dwait",    32'(bus.dwait),  32'd1);
    tick(); tick();
    chk("cw_dwait_done", 32'(bus.dwait), 32'd0);
    chk("cw_iwait_hold", 32'(bus.iwait), 32'd1);
    tick();
    bus.dWEN = 1'b0; #1;
    chk("cw_idle_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("cw_idle_dwait",  32'(bus.dwait),  32'd1);
    tick();
    chk("ci_ramREN",   32'(bus.ramREN), 32'd1);
    chk("ci_ramaddr",  bus.ramaddr,     32'h80);
    chk("ci_ramstore", bus.ramstore,    32'h0);
    tick(); tick();
    chk("ci_iwait_done", 32'(bus.iwait), 32'd0);
    chk("ci_dwait_hold", 32'(bus.dwait), 32'd1);
    chk("ci_iload",      bus.iload,      32'h12345678);
    tick();
    bus.iREN = 1'b0; #1;

    // both ports requesting continuously; dREN+dWEN together must write
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hA5;
    bus.iREN = 1'b1; bus.iaddr = 32'hC0;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = RR ? ((k % 2) == 0) : 1'b1;
      tick();
      chk($sformatf("cont%0d_ramaddr", k), bus.ramaddr, exp_d ? 32'h200 : 32'hC0);
      chk($sformatf("cont%0d_ramWEN", k),  32'(bus.ramWEN), 32'(exp_d));
      chk($sformatf("cont%0d_ramREN", k),  32'(bus.ramREN), 32'(!exp_d));
      tick(); tick();
      chk($sformatf("cont%0d_dwait", k), 32'(bus.dwait), 32'(!exp_d));
      chk($sformatf("cont%0d_iwait", k), 32'(bus.iwait), 32'(exp_d));
      tick();
    end
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.iREN = 1'b0; #1;

    // RAM error during a data read
    err_inj = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramload = 32'hBAD0BAD0;
    tick();
    chk("err_ramREN", 32'(bus.ramREN), 32'd1);
    tick(); tick();
    chk("err_dwait",      32'(bus.dwait),  32'd0);
    chk("err_dload",      bus.dload,       32'hBAD0BAD0);
    chk("err_memerr_pre", 32'(bus.memerr), 32'd0);
    tick();
    bus.dREN = 1'b0; err_inj = 1'b0; #1;
    chk("err_memerr", 32'(bus.memerr), 32'd1);
    chk("err_dwait_idle", 32'(bus.dwait), 32'd1);
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    tick(); tick(); tick();
    chk("ok_iwait",       32'(bus.iwait),  32'd0);
    chk("ok_memerr_hold", 32'(bus.memerr), 32'd1);
    tick();
    bus.iREN = 1'b0; #1;
    chk("memerr_sticky", 32'(bus.memerr), 32'd1);

    // abort: data request dropped while RAM is busy
    lat = 10; bus.dREN = 1'b1; bus.daddr = 32'h400;
    tick();
    chk("ab_ramREN",   32'(bus.ramREN),   32'd1);
    chk("ab_ramstate", 32'(bus.ramstate), 32'd1);
    tick();
    bus.dREN = 1'b0; #1;
    chk("ab_ramREN_drop", 32'(bus.ramREN), 32'd0);
    chk("ab_dwait",       32'(bus.dwait),  32'd1);
    tick();
    chk("ab_idle_ramREN", 32'(bus.ramREN), 32'd0);
    chk("ab_idle_dwait",  32'(bus.dwait),  32'd1);
    bus.iREN = 1'b1; bus.iaddr = 32'h48;
    tick();
    chk("ab_regrant_ramREN",  32'(bus.ramREN), 32'd1);
    chk("ab_regrant_ramaddr", bus.ramaddr,     32'h48);

    // reset mid-transaction
    tick();
    nRST = 1'b1; #1;
    chk("mr_ramREN",  32'(bus.ramREN), 32'd0);
    chk("mr_ramaddr", bus.ramaddr,     32'h0);
    chk("mr_iwait",   32'(bus.iwait),  32'd1);
    chk("mr_memerr",  32'(bus.memerr), 32'd0);
    tick();
    nRST = 1'b0; lat = 2;
    tick();
    chk("mr_restart_ramREN",  32'(bus.ramREN), 32'd1);
    chk("mr_restart_ramaddr", bus.ramaddr,     32'h48);
    tick(); tick();
    chk("mr_restart_iwait", 32'(bus.iwait), 32'd0);
    tick();
    bus.iREN = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
